// File: rtl/gate_test_sequencer_pkg.sv
// Shared definitions for the gate test sequencer.
//   state_t     : FSM state encoding, also exported on the interface for debug.
//   DEF_N_IN    : default gate input count for the lab builds.
//   DEF_DWELL   : default settle cycles per vector.
//   cnt_width() : register width needed to count 0..n-1 (never below 1 bit).
package gate_test_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_N_IN  = 2;
   localparam int DEF_DWELL = 2;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Bundle between the lab top level and the gate test sequencer.
//   start      : level request; a run begins on any cycle where start=1 while
//                the sequencer is idle. There is no ready/ack: while busy or in
//                the done cycle the level is ignored, and holding it high
//                simply re-arms a new run in the first idle cycle.
//   exp_table  : expected truth table, bit i = expected gate_out for gate_in=i
//   gate_out   : output of the gate under test
//   gate_in    : stimulus vector to the gate under test
//   busy/done  : run in progress / one-cycle end-of-run pulse
//   pass, err_count, first_fail, fail_seen : result of the last or current run
//   state      : FSM state, debug visibility only
// Modports: master = lab top / bench side, slave = sequencer side.
interface gate_test_sequencer_if
   import gate_test_sequencer_pkg::*;
#(
   parameter int N_IN = DEF_N_IN
);
   localparam int NV = 1 << N_IN;

   logic            start;
   logic [NV-1:0]   exp_table;
   logic            gate_out;
   logic [N_IN-1:0] gate_in;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_fail;
   logic            fail_seen;
   state_t          state;

   modport master (
      output start, exp_table, gate_out,
      input  gate_in, busy, done, pass, err_count, first_fail, fail_seen, state
   );

   modport slave (
      input  start, exp_table, gate_out,
      output gate_in, busy, done, pass, err_count, first_fail, fail_seen, state
   );

endinterface

// File: rtl/gate_test_sequencer_dwell_timer.sv
// Settle timer: counts while en=1, clears on clr or rst.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (priority over en)
//   en       : count enable
//   tc       : terminal count, high when the count equals DWELL-1
module gate_test_sequencer_dwell_timer
   import gate_test_sequencer_pkg::*;
#(
   parameter int DWELL = DEF_DWELL
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = cnt_width(DWELL);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == CW'(DWELL - 1));

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus controller for a small N_IN-input combinational gate.
// Steps gate_in through 0..2^N_IN-1, lets each vector settle for DWELL cycles,
// samples gate_out for one CHECK cycle and compares it with the truth table
// captured at start. Reports pass, mismatch count and first failing vector.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gate_test_sequencer_if slave modport (see interface header)
module gate_test_sequencer
   import gate_test_sequencer_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int DWELL = DEF_DWELL
) (
   input  logic                        clk,
   input  logic                        rst,
   gate_test_sequencer_if.slave        bus
);
   localparam int              NV   = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

   state_t          state;
   logic [NV-1:0]   exp_q;
   logic [N_IN-1:0] idx;
   logic [N_IN-1:0] gate_in_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [N_IN:0]   err_q;
   logic [N_IN-1:0] first_fail_q;
   logic            fail_seen_q;
   logic            dwell_tc;
   logic            mismatch;

   // The timer only runs in SETTLE, so every SETTLE entry starts from zero.
   gate_test_sequencer_dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (state != ST_SETTLE),
      .en  (state == ST_SETTLE),
      .tc  (dwell_tc)
   );

   assign mismatch = (bus.gate_out != exp_q[idx]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         exp_q        <= '0;
         idx          <= '0;
         gate_in_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         first_fail_q <= '0;
         fail_seen_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  exp_q        <= bus.exp_table;
                  err_q        <= '0;
                  fail_seen_q  <= 1'b0;
                  first_fail_q <= '0;
                  pass_q       <= 1'b0;
                  idx          <= '0;
                  gate_in_q    <= '0;
                  busy_q       <= 1'b1;
                  state        <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (dwell_tc) begin
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // err_q cannot saturate: at most NV mismatches fit in N_IN+1 bits.
               if (mismatch) begin
                  err_q <= err_q + 1'b1;
                  if (!fail_seen_q) begin
                     first_fail_q <= idx;
                     fail_seen_q  <= 1'b1;
                  end
               end
               // Last vector found by compare; gate_in keeps NV-1 after the run.
               if (idx == LAST) begin
                  state <= ST_DONE;
               end else begin
                  idx       <= idx + 1'b1;
                  gate_in_q <= idx + 1'b1;
                  state     <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               pass_q <= (err_q == '0);
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gate_in    = gate_in_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.first_fail = first_fail_q;
   assign bus.fail_seen  = fail_seen_q;
   assign bus.state      = state;

endmodule

// File: tb/tb_gate_test_sequencer.sv
module tb_gate_test_sequencer;
   import gate_test_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   logic [3:0] tt_a;
   logic [7:0] tt_b;

   gate_test_sequencer_if #(.N_IN(2)) a_if ();
   gate_test_sequencer_if #(.N_IN(3)) b_if ();

   gate_test_sequencer #(.N_IN(2), .DWELL(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   gate_test_sequencer #(.N_IN(3), .DWELL(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   // Gates under test: plain truth-table lookups fed by gate_in.
   always_comb a_if.gate_out = tt_a[a_if.gate_in];
   always_comb b_if.gate_out = tt_b[b_if.gate_in];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gate_tt(input int kind, input int nv);
      logic [7:0] t;
      t = '0;
      for (int i = 0; i < nv; i++) begin
         case (kind)
            0:       t[i] = (i == nv - 1);   // AND: only all-ones input gives 1
            1:       t[i] = (i != 0);        // OR: any set input gives 1
            default: t[i] = 1'b0;            // stuck-at-0 gate
         endcase
      end
      return t;
   endfunction

   function automatic int count_err(input logic [7:0] tbl, input logic [7:0] tt, input int nv);
      int n;
      n = 0;
      for (int i = 0; i < nv; i++) if (tbl[i] != tt[i]) n++;
      return n;
   endfunction

   function automatic int first_err(input logic [7:0] tbl, input logic [7:0] tt, input int nv);
      for (int i = 0; i < nv; i++) if (tbl[i] != tt[i]) return i;
      return 0;
   endfunction

   // ---------------- driver helpers ----------------
   task automatic set_start(input int inst, input logic v);
      if (inst == 0) a_if.start = v; else b_if.start = v;
   endtask

   task automatic set_tbl(input int inst, input logic [7:0] t);
      if (inst == 0) a_if.exp_table = t[3:0]; else b_if.exp_table = t;
   endtask

   task automatic set_tt(input int inst, input logic [7:0] t);
      if (inst == 0) tt_a = t[3:0]; else tt_b = t;
   endtask

   function automatic logic [31:0] get_gi(input int inst);
      return (inst == 0) ? 32'(a_if.gate_in) : 32'(b_if.gate_in);
   endfunction
   function automatic logic get_busy(input int inst);
      return (inst == 0) ? a_if.busy : b_if.busy;
   endfunction
   function automatic logic get_done(input int inst);
      return (inst == 0) ? a_if.done : b_if.done;
   endfunction
   function automatic logic get_pass(input int inst);
      return (inst == 0) ? a_if.pass : b_if.pass;
   endfunction
   function automatic logic get_fs(input int inst);
      return (inst == 0) ? a_if.fail_seen : b_if.fail_seen;
   endfunction
   function automatic logic [31:0] get_err(input int inst);
      return (inst == 0) ? 32'(a_if.err_count) : 32'(b_if.err_count);
   endfunction
   function automatic logic [31:0] get_ff(input int inst);
      return (inst == 0) ? 32'(a_if.first_fail) : 32'(b_if.first_fail);
   endfunction

   task automatic check_results(input int inst, input string tag, input logic [7:0] tbl,
                                input logic [7:0] tt, input int nv);
      int e;
      e = count_err(tbl, tt, nv);
      check({tag, "_err"},   get_err(inst), 32'(e));
      check({tag, "_ff"},    get_ff(inst),  32'(first_err(tbl, tt, nv)));
      check({tag, "_fs"},    32'(get_fs(inst)),   32'(e != 0));
      check({tag, "_pass"},  32'(get_pass(inst)), 32'(e == 0));
   endtask

   // One full run. Called #1 after a rising edge with the DUT idle.
   // hold: keep start high through the run and expect an immediate restart.
   // toggle: invert exp_table partway through the run.
   task automatic run(input int inst, input logic [7:0] tbl_in, input logic [7:0] tt,
                      input bit hold, input bit toggle, input string tag);
      int         nv, dw, lat, done_at, g, done2;
      logic [7:0] tbl, cap, mask;
      bit         seq_ok;
      nv   = (inst == 0) ? 4 : 8;
      dw   = (inst == 0) ? 2 : 1;
      lat  = nv * (dw + 1) + 1;
      mask = (inst == 0) ? 8'h0F : 8'hFF;
      tbl  = tbl_in & mask;
      set_tt(inst, tt & mask);
      set_tbl(inst, tbl);
      set_start(inst, 1'b1);
      seq_ok  = 1'b1;
      done_at = -1;
      for (int k = 0; k <= lat + 2 && done_at < 0; k++) begin
         @(posedge clk); #1;
         if (!hold) set_start(inst, 1'b0);
         if (toggle && k == 3) set_tbl(inst, ~tbl & mask);
         if (get_done(inst)) begin
            done_at = k;
         end else begin
            g = k / (dw + 1);
            if (g > nv - 1) g = nv - 1;
            if (get_gi(inst) != 32'(g) || !get_busy(inst)) seq_ok = 1'b0;
         end
      end
      check({tag, "_latency"}, 32'(done_at), 32'(lat));
      check({tag, "_gate_in_seq"}, 32'(seq_ok), 32'd1);
      check({tag, "_busy_end"}, 32'(get_busy(inst)), 32'd0);
      check({tag, "_gi_hold"}, get_gi(inst), 32'(nv - 1));
      check_results(inst, tag, tbl, tt & mask, nv);
      if (hold) begin
         cap = toggle ? (~tbl & mask) : tbl;
         @(posedge clk); #1;
         set_start(inst, 1'b0);
         check({tag, "_restart_busy"}, 32'(get_busy(inst)), 32'd1);
         check({tag, "_restart_gi"}, get_gi(inst), 32'd0);
         check({tag, "_restart_done"}, 32'(get_done(inst)), 32'd0);
         done2 = -1;
         for (int k = 1; k <= lat + 2 && done2 < 0; k++) begin
            @(posedge clk); #1;
            if (get_done(inst)) done2 = k;
         end
         check({tag, "_restart_latency"}, 32'(done2), 32'(lat));
         check_results(inst, {tag, "_r2"}, cap, tt & mask, nv);
      end else begin
         repeat (3) @(posedge clk);
         #1;
         check({tag, "_done_pulse"}, 32'(get_done(inst)), 32'd0);
         check({tag, "_persist_err"}, get_err(inst), 32'(count_err(tbl, tt & mask, nv)));
         check({tag, "_persist_pass"}, 32'(get_pass(inst)), 32'(count_err(tbl, tt & mask, nv) == 0));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] rt, rtab;
      bit         hit;
      rst          = 1'b1;
      a_if.start   = 1'b0;
      b_if.start   = 1'b0;
      a_if.exp_table = '0;
      b_if.exp_table = '0;
      tt_a         = '0;
      tt_b         = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_state",  32'(a_if.state), 32'(ST_IDLE));
      check("rst_gi",     32'(a_if.gate_in), 32'd0);
      check("rst_busy",   32'(a_if.busy), 32'd0);
      check("rst_done",   32'(a_if.done), 32'd0);
      check("rst_pass",   32'(a_if.pass), 32'd0);
      check("rst_err",    32'(a_if.err_count), 32'd0);
      check("rst_ff",     32'(a_if.first_fail), 32'd0);
      check("rst_fs",     32'(a_if.fail_seen), 32'd0);
      check("rst_b_busy", 32'(b_if.busy), 32'd0);

      // 1: AND gate, correct table
      run(0, 8'h08, gate_tt(0, 4), 1'b0, 1'b0, "and_ok");
      // 2: OR gate against AND table -> mismatches at 1,2
      run(0, 8'h08, gate_tt(1, 4), 1'b0, 1'b0, "or_vs_and");

      // 3: reset while vector 2 is settling (one mismatch already counted)
      set_tt(0, gate_tt(1, 4));
      set_tbl(0, 8'h08);
      set_start(0, 1'b1);
      @(posedge clk); #1;
      set_start(0, 1'b0);
      hit = 1'b0;
      for (int k = 0; k < 30 && !hit; k++) begin
         @(posedge clk); #1;
         if (a_if.gate_in == 2'd2) hit = 1'b1;
      end
      check("mid_reach_gi2", 32'(hit), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_state", 32'(a_if.state), 32'(ST_IDLE));
      check("mid_rst_gi",    32'(a_if.gate_in), 32'd0);
      check("mid_rst_busy",  32'(a_if.busy), 32'd0);
      check("mid_rst_err",   32'(a_if.err_count), 32'd0);
      check("mid_rst_fs",    32'(a_if.fail_seen), 32'd0);
      run(0, 8'h08, gate_tt(0, 4), 1'b0, 1'b0, "after_rst");

      // 4: start held for the whole run, table inverted mid-run
      run(0, 8'h08, gate_tt(0, 4), 1'b1, 1'b1, "hold_toggle");

      // 5: stuck-at-0 gate against all-ones table, then a clean AND run
      run(0, 8'h0F, gate_tt(2, 4), 1'b0, 1'b0, "stuck0");
      run(0, 8'h08, gate_tt(0, 4), 1'b0, 1'b0, "and_after_stuck");

      // 6: three-input AND, single-cycle dwell
      run(1, 8'h80, gate_tt(0, 8), 1'b0, 1'b0, "and3");
      run(1, 8'h80, gate_tt(1, 8), 1'b0, 1'b0, "or3_vs_and3");

      // Randomized tables and random gates on both instances
      for (int r = 0; r < 8; r++) begin
         rtab = 8'($urandom);
         rt   = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rt = rtab;
         run(r % 2, rtab, rt, 1'b0, 1'b0, $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
